elevator_door_ctrl: RTL

Door-sequencing controller for the elevator car: a 4-state FSM that opens the door on request, holds it open for a programmed number of seconds and closes it, with obstruction and button override. Sits directly downstream of `frequency_divider`. Uses its `CLK_1Hz` output as the seconds time base and its `CLK_2Hz` output for the closing-warning blink. Both are counter bits in the `CLK` domain, so they need no synchronizer. Feeds `DOOR_CLOSED` to the car-motion controller, which only moves the car while that output is high.

---
 rtl/elevator_door_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/elevator_door_ctrl.sv
// elevator_door_ctrl
// Door sequencing for the elevator car: open on request, dwell for a
// programmed number of seconds, close, with obstruction and button override.
// CLK_1Hz / CLK_2Hz are divider bits already in the CLK domain.
`timescale 1ns/1ps

module elevator_door_ctrl #(
    parameter int OPEN_TIME_S = 5,
    parameter int MOVE_TIME_S = 2,
    parameter int CNT_W       = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       CLK_1Hz,
    input  logic       CLK_2Hz,
    input  logic       OPEN_REQ,
    input  logic       CLOSE_REQ,
    input  logic       OBSTRUCT,
    output logic       MOTOR_OPEN,
    output logic       MOTOR_CLOSE,
    output logic       DOOR_CLOSED,
    output logic       WARN_LED,
    output logic [1:0] STATE
);

    typedef enum logic [1:0] {
        ST_CLOSED  = 2'b00,
        ST_OPENING = 2'b01,
        ST_OPEN    = 2'b10,
        ST_CLOSING = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] OPEN_LOAD = CNT_W'(OPEN_TIME_S);
    localparam logic [CNT_W-1:0] MOVE_LOAD = CNT_W'(MOVE_TIME_S);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] sec_cnt;
    logic [CNT_W-1:0] load_val;
    logic             load;
    logic             prev_1hz;
    logic             tick;
    logic             expiry;

    // A tick is the first CLK cycle in which the 1 Hz bit is seen high.
    assign tick   = CLK_1Hz & ~prev_1hz;
    assign expiry = tick & (sec_cnt == CNT_ONE);

    // Edge-detect history; resets high so a high CLK_1Hz at release is not a tick.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            prev_1hz <= 1'b1;
        end else begin
            prev_1hz <= CLK_1Hz;
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= ST_CLOSED;
        end else begin
            state <= next_state;
        end
    end

    // Seconds down-counter: a load wins over a tick, and it never goes below zero.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sec_cnt <= '0;
        end else if (load) begin
            sec_cnt <= load_val;
        end else if (tick && (sec_cnt != '0)) begin
            sec_cnt <= sec_cnt - CNT_ONE;
        end
    end

    // Next-state and counter-load decision; requests outrank a coincident tick.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        load_val   = '0;
        case (state)
            ST_CLOSED: begin
                if (OPEN_REQ || OBSTRUCT) begin
                    next_state = ST_OPENING;
                    load       = 1'b1;
                    load_val   = MOVE_LOAD;
                end
            end
            ST_OPENING: begin
                if (expiry) begin
                    next_state = ST_OPEN;
                    load       = 1'b1;
                    load_val   = OPEN_LOAD;
                end
            end
            ST_OPEN: begin
                if (OBSTRUCT || OPEN_REQ) begin
                    load     = 1'b1;
                    load_val = OPEN_LOAD;
                end else if (CLOSE_REQ || expiry) begin
                    next_state = ST_CLOSING;
                    load       = 1'b1;
                    load_val   = MOVE_LOAD;
                end
            end
            ST_CLOSING: begin
                if (OBSTRUCT || OPEN_REQ) begin
                    next_state = ST_OPENING;
                    load       = 1'b1;
                    load_val   = MOVE_LOAD;
                end else if (expiry) begin
                    next_state = ST_CLOSED;
                    load       = 1'b1;
                    load_val   = '0;
                end
            end
            default: begin
                next_state = ST_CLOSED;
                load       = 1'b1;
                load_val   = '0;
            end
        endcase
    end

    // Moore output decode from the state register; the warning blinks at 2 Hz.
    always_comb begin
        MOTOR_OPEN  = 1'b0;
        MOTOR_CLOSE = 1'b0;
        DOOR_CLOSED = 1'b0;
        WARN_LED    = 1'b0;
        case (state)
            ST_CLOSED:  DOOR_CLOSED = 1'b1;
            ST_OPENING: MOTOR_OPEN  = 1'b1;
            ST_OPEN:    ;
            ST_CLOSING: begin
                MOTOR_CLOSE = 1'b1;
                WARN_LED    = CLK_2Hz;
            end
            default:    DOOR_CLOSED = 1'b1;
        endcase
    end

    assign STATE = state;

endmodule
